// File: rtl/ai_ram_avst_unloader_if.sv
// RAM read port plus Avalon-ST source bundle between the unloader and its neighbours.
interface ai_ram_avst_unloader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] q_addr;
  logic              q_read;
  logic [7:0]        q_data1;
  logic [7:0]        q_data2;
  logic [7:0]        q_data3;
  logic [7:0]        q_data4;
  logic [31:0]       avs_src_data;
  logic              avs_src_valid;
  logic              avs_src_startofpacket;
  logic              avs_src_endofpacket;
  logic              avs_src_ready;

  // Unloader side: drives RAM address/strobe and the stream source.
  modport master (
    output q_addr, q_read,
    output avs_src_data, avs_src_valid, avs_src_startofpacket, avs_src_endofpacket,
    input  q_data1, q_data2, q_data3, q_data4,
    input  avs_src_ready
  );

  // RAM model / stream sink side.
  modport slave (
    input  q_addr, q_read,
    input  avs_src_data, avs_src_valid, avs_src_startofpacket, avs_src_endofpacket,
    output q_data1, q_data2, q_data3, q_data4,
    output avs_src_ready
  );
endinterface

// File: rtl/ai_ram_avst_unloader.sv
// Streams AI RAM words 0..len-1 out as 32-bit Avalon-ST beats (sop on first, eop on last).
//
// state | meaning
// IDLE  | waiting for start; len=0 start only pulses done
// READ  | q_read asserted for the current word address
// WAIT  | RAM read latency; capture the four lanes
// SEND  | beat presented on the stream until accepted
module ai_ram_avst_unloader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  ai_ram_avst_unloader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, SEND} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            f_state_q, f_state_d;
  logic [ADDR_W-1:0] f_addr_q,  f_addr_d;
  logic [ADDR_W:0]   f_cnt_q,   f_cnt_d;
  logic [31:0]       f_mem_q,   f_mem_d;
  logic              f_first_q, f_first_d;
  logic              done_q,    done_d;

  logic [ADDR_W:0]   len_clamped;
  logic              last_beat;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign last_beat   = (f_cnt_q == {{ADDR_W{1'b0}}, 1'b1});

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_state_q <= IDLE;
      f_addr_q  <= '0;
      f_cnt_q   <= '0;
      f_mem_q   <= '0;
      f_first_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      f_state_q <= f_state_d;
      f_addr_q  <= f_addr_d;
      f_cnt_q   <= f_cnt_d;
      f_mem_q   <= f_mem_d;
      f_first_q <= f_first_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; the address only advances on a non-final beat, so it never wraps.
  always_comb begin
    f_state_d = f_state_q;
    f_addr_d  = f_addr_q;
    f_cnt_d   = f_cnt_q;
    f_mem_d   = f_mem_q;
    f_first_d = f_first_q;
    done_d    = 1'b0;
    case (f_state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            f_state_d = READ;
            f_cnt_d   = len_clamped;
            f_addr_d  = '0;
            f_first_d = 1'b1;
          end
        end
      end
      READ: f_state_d = WAIT;
      WAIT: begin
        f_mem_d   = {bus.q_data4, bus.q_data3, bus.q_data2, bus.q_data1};
        f_state_d = SEND;
      end
      SEND: begin
        if (bus.avs_src_ready) begin
          if (last_beat) begin
            f_state_d = IDLE;
            done_d    = 1'b1;
          end else begin
            f_state_d = READ;
            f_cnt_d   = f_cnt_q - 1'b1;
            f_addr_d  = f_addr_q + 1'b1;
            f_first_d = 1'b0;
          end
        end
      end
      default: f_state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; ready never reaches valid combinationally.
  always_comb begin
    busy                      = (f_state_q != IDLE);
    done                      = done_q;
    bus.q_read                = (f_state_q == READ);
    bus.q_addr                = f_addr_q;
    bus.avs_src_valid         = (f_state_q == SEND);
    bus.avs_src_data          = (f_state_q == SEND) ? f_mem_q : 32'h0;
    bus.avs_src_startofpacket = (f_state_q == SEND) && f_first_q;
    bus.avs_src_endofpacket   = (f_state_q == SEND) && last_beat;
  end

endmodule

// File: tb/tb_ai_ram_avst_unloader.sv
// Bench for the AI RAM stream unloader: RAM model, beat scoreboard, timing and stall checks.
module tb_ai_ram_avst_unloader;
  localparam int ADDR_W = 14;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;

  ai_ram_avst_unloader_if #(.ADDR_W(ADDR_W)) bus ();

  ai_ram_avst_unloader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];

  // RAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.q_read)
      {bus.q_data4, bus.q_data3, bus.q_data2, bus.q_data1} <= mem[bus.q_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall on beat 1, 3 ready high plus a start pulse mid-transfer.
  // reset_at >= 0 asserts rst while that beat is presented.
  task automatic run_pkt(input int req, input int mode, input int reset_at);
    int          n;
    int          beat;
    int          cyc;
    int          last_acc;
    int          stall_left;
    bit          stalled_once;
    bit          finished;
    bit          seen_valid;
    bit          p_stall;
    logic [31:0] p_data;
    logic        p_sop, p_eop;
    n            = (req > WORDS) ? WORDS : req;
    beat         = 0;
    cyc          = 1;
    last_acc     = -100;
    stall_left   = 0;
    stalled_once = 0;
    finished     = 0;
    seen_valid   = 0;
    p_stall      = 0;
    p_data       = '0;
    p_sop        = 0;
    p_eop        = 0;

    @(negedge clk);
    start = 1'b1;
    len   = req[ADDR_W:0];
    @(negedge clk);
    start = 1'b0;
    len   = '0;

    if (n == 0) begin
      chk("zero_len_done", 64'(done), 64'd1);
      chk("zero_len_busy", 64'(busy), 64'd0);
      chk("zero_len_valid", 64'(bus.avs_src_valid), 64'd0);
      @(negedge clk);
      chk("zero_len_done_drop", 64'(done), 64'd0);
      chk("zero_len_valid2", 64'(bus.avs_src_valid), 64'd0);
      return;
    end

    while (!finished && cyc < n * 40 + 100) begin
      if (mode == 3 && cyc == 5) begin
        start = 1'b1;
        len   = 15'd9;
      end else begin
        start = 1'b0;
      end

      if (reset_at >= 0 && bus.avs_src_valid && beat == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 64'(bus.avs_src_valid), 64'd0);
        chk("rst_sop", 64'(bus.avs_src_startofpacket), 64'd0);
        chk("rst_eop", 64'(bus.avs_src_endofpacket), 64'd0);
        chk("rst_data", 64'(bus.avs_src_data), 64'd0);
        chk("rst_qread", 64'(bus.q_read), 64'd0);
        chk("rst_qaddr", 64'(bus.q_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (4) begin
          @(negedge clk);
          chk("post_rst_done", 64'(done), 64'd0);
          chk("post_rst_valid", 64'(bus.avs_src_valid), 64'd0);
        end
        return;
      end

      case (mode)
        1: bus.avs_src_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.avs_src_valid && beat == 1 && !stalled_once) begin
            stalled_once = 1;
            stall_left   = 5;
          end
          bus.avs_src_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: bus.avs_src_ready = 1'b1;
      endcase

      if (beat == n && cyc == last_acc + 1) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("valid_after", 64'(bus.avs_src_valid), 64'd0);
        finished = 1;
      end else begin
        chk("done_low", 64'(done), 64'd0);
      end

      if (p_stall) begin
        chk("hold_valid", 64'(bus.avs_src_valid), 64'd1);
        chk("hold_data", 64'(bus.avs_src_data), 64'(p_data));
        chk("hold_sop", 64'(bus.avs_src_startofpacket), 64'(p_sop));
        chk("hold_eop", 64'(bus.avs_src_endofpacket), 64'(p_eop));
      end

      if (bus.avs_src_valid) begin
        chk("no_read_in_send", 64'(bus.q_read), 64'd0);
        if (!seen_valid) begin
          seen_valid = 1;
          chk("first_latency", 64'(cyc), 64'd3);
        end
      end

      if (bus.q_read)
        chk("q_addr", 64'(bus.q_addr), 64'(beat));

      if (!finished && bus.avs_src_valid && bus.avs_src_ready) begin
        chk("beat_data", 64'(bus.avs_src_data), 64'(mem[beat]));
        chk("beat_sop", 64'(bus.avs_src_startofpacket), 64'(beat == 0));
        chk("beat_eop", 64'(bus.avs_src_endofpacket), 64'(beat == n - 1));
        if ((mode == 0 || mode == 3) && beat > 0)
          chk("beat_spacing", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
        beat++;
      end

      p_stall = bus.avs_src_valid && !bus.avs_src_ready;
      p_data  = bus.avs_src_data;
      p_sop   = bus.avs_src_startofpacket;
      p_eop   = bus.avs_src_endofpacket;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.avs_src_ready = 1'b1;
    chk("pkt_complete", 64'(finished), 64'd1);
    chk("beat_count", 64'(beat), 64'(n));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    bus.avs_src_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(bus.avs_src_valid), 64'd0);
    chk("reset_qread", 64'(bus.q_read), 64'd0);
    chk("reset_data", 64'(bus.avs_src_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[0] = 32'h11223344;
    run_pkt(1, 0, -1);

    for (int i = 0; i < 4; i++) mem[i] = 32'(i) * 32'h01010101;
    run_pkt(4, 0, -1);
    run_pkt(3, 2, -1);
    run_pkt(4, 3, -1);
    run_pkt(0, 0, -1);

    run_pkt(6, 0, 2);
    run_pkt(2, 0, -1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_pkt(int'($urandom_range(1, 40)), 1, -1);
    end

    run_pkt(20000, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ai_ram_avst_unloader.md
Name: ai_ram_avst_unloader

Overview:
- Avalon-ST source that streams the AI RAM contents out as 32-bit words. It is the read-back counterpart of the AI RAM stream loader.
- On a start request it reads word addresses 0..len-1 from the 4-lane byte RAM (14-bit word address) and emits one beat per word, with startofpacket on the first beat and endofpacket on the last.
- It sits between the AI RAM read port and the stream fabric toward DMA/host.

Parameters:
- ADDR_W, 14, RAM word-address width; max packet = 2^ADDR_W words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle transfer request
- len  in  ADDR_W+1  words to send, sampled with start
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse after last beat accepted (or zero-length start)
- q_addr  out  ADDR_W  RAM word read address
- q_read  out  1  RAM read strobe
- q_data1  in  8  RAM lane 0 read data, valid cycle after q_read
- q_data2  in  8  RAM lane 1 read data
- q_data3  in  8  RAM lane 2 read data
- q_data4  in  8  RAM lane 3 read data
- avs_src_data  out  32  stream data
- avs_src_valid  out  1  stream valid
- avs_src_startofpacket  out  1  first beat marker
- avs_src_endofpacket  out  1  last beat marker
- avs_src_ready  in  1  sink ready

Behaviour:
- Registered state: f_state, f_addr (ADDR_W), f_cnt (ADDR_W+1, words remaining), f_mem (32), f_first, done register. All clear on rst.
- Outputs are combinational from registered state only. There is no combinational path from avs_src_ready to avs_src_valid.
- After any clock edge with rst=1, every output is 0 and state is IDLE.
- IDLE:
  - busy=0.
  - start with len in 1..2^ADDR_W: latch f_cnt=len, f_addr=0, f_first=1, go READ.
  - len > 2^ADDR_W: clamp to 2^ADDR_W.
  - start with len=0: no beats; done=1 on the next cycle; stay IDLE.
- READ: q_read=1, q_addr=f_addr, busy=1, go WAIT.
- WAIT: RAM has 1-cycle read latency. Capture f_mem = {q_data4,q_data3,q_data2,q_data1}, go SEND.
- SEND:
  - avs_src_valid=1, avs_src_data=f_mem.
  - startofpacket=f_first.
  - endofpacket=(f_cnt==1).
  - On avs_src_ready=1:
    - If endofpacket: go IDLE, done=1 next cycle.
    - Otherwise: f_cnt-1, f_addr+1, f_first=0, go READ.
  - On avs_src_ready=0: hold data/valid/sop/eop stable; no RAM access.
- Byte mapping: data[7:0]=lane0 .. data[31:24]=lane3, identical to the loader so a load/unload round trip is bit-exact.
- Throughput: 1 beat per 3 cycles with ready held high. First valid appears 3 cycles after start.
- Boundaries:
  - Full-size packet ends at f_addr=2^ADDR_W-1 with eop; f_addr never wraps during a transfer.
  - start while busy is ignored; len is not resampled.
  - q_read is never asserted outside READ.
  - Reset mid-packet: valid drops immediately after the reset edge, no eop and no done are emitted, and the next start begins a fresh packet at address 0 with sop.

Test Plan:
- RAM word0=0x11223344, start len=1, ready=1 → valid on cycle 3 with data 0x11223344, sop=1, eop=1; done pulse next cycle; busy low after.
- RAM[i]=i*0x01010101, len=4, ready=1 → 4 beats of data 0x00000000..0x03030303, sop only on beat 0, eop only on beat 3, q_addr sequence 0,1,2,3, beats 3 cycles apart.
- len=3, ready low 5 cycles during beat 1 → beat 1 data/sop/eop held stable, no q_read while stalled, packet completes with correct order.
- start pulsed again mid-transfer with len=9 → ignored, original len=4 packet unchanged; start len=0 in IDLE → done one cycle later, valid never asserted.
- rst asserted during beat 2 of len=6 → all outputs 0 after the reset edge, no done; restart len=2 → sop at address 0, eop at address 1.
- len=16384 (and len=20000, clamped) → 16384 beats, last q_addr=16383 carries eop, single done pulse.
